// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and helpers for the memory arbiter
// Size codes, FSM states, requester ids and the alignment rule.
package mem_arb_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    WAIT   = 2'b10
  } arb_state_e;

  // Size 11 has no legal encoding, so it is always reported as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, load/store and memory signals of the arbiter
// slave is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [1:0]  d_size;
  logic        d_unsigned;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_err;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_size, d_unsigned, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_err, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_size, d_unsigned, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_err, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/mem_lane_fmt.sv
// rtl/mem_lane_fmt.sv - byte enables, store replication and load extract/extend
// Purely combinational; driven from the arbiter's latched request fields.
module mem_lane_fmt
  import mem_arb_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] lane;

  assign lane = rdata_i >> {off_i, 3'b000};

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{~unsigned_i & lane[7]}}, lane[7:0]};
      end
      SZ_HALF: begin
        be_o    = 4'b0011 << off_i;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{~unsigned_i & lane[15]}}, lane[15:0]};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch vs load/store arbiter for one single-port memory
// Optional fetch starvation guard: MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);

  arb_state_e  state_q;
  logic [2:0]  lat_q;
  logic        owner_q;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic        mem_en_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;

  logic        idle;
  logic        force_if;
  logic        if_win;
  logic        d_win;
  logic        d_bad;
  logic        rd_done;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata;
  logic [31:0] fmt_rdata;
  logic        unused_addr;

  assign unused_addr = ^bus.if_addr[1:0];

  // Grants are gated by rst_n so every output reads 0 while reset is held.
  assign idle   = rst_n && (state_q == IDLE);
  assign d_bad  = is_misaligned(bus.d_size, bus.d_addr[1:0]);
  assign if_win = idle && bus.if_req && (!bus.d_req || force_if);
  assign d_win  = idle && bus.d_req && !if_win;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] starve_q;
  logic [3:0] starve_d;

  assign force_if = (starve_q == 4'(STARVE_MAX));

  always_comb begin
    starve_d = starve_q;
    if (!bus.if_req || if_win) starve_d = 4'd0;
    else if (d_win)            starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= 4'd0;
    else        starve_q <= starve_d;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^4'(STARVE_MAX);
  assign force_if   = 1'b0;
`endif

  assign rd_done = (state_q == WAIT) && (lat_q == 3'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lat_q      <= 3'd0;
      owner_q    <= REQ_IF;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= SZ_BYTE;
      off_q      <= 2'b00;
      wdata_q    <= 32'h0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= 32'h0;
    end else begin
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= 32'h0;
      case (state_q)
        IDLE: begin
          if (if_win) begin
            owner_q    <= REQ_IF;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= SZ_WORD;
            off_q      <= 2'b00;
            wdata_q    <= 32'h0;
            mem_en_q   <= 1'b1;
            mem_addr_q <= {bus.if_addr[31:2], 2'b00};
            state_q    <= ACCESS;
          end else if (d_win && !d_bad) begin
            owner_q    <= REQ_D;
            we_q       <= bus.d_we;
            uns_q      <= bus.d_unsigned;
            size_q     <= bus.d_size;
            off_q      <= bus.d_addr[1:0];
            wdata_q    <= bus.d_wdata;
            mem_en_q   <= 1'b1;
            mem_we_q   <= bus.d_we;
            mem_addr_q <= {bus.d_addr[31:2], 2'b00};
            state_q    <= ACCESS;
          end
        end
        ACCESS: begin
          if (we_q) begin
            state_q <= IDLE;
          end else begin
            state_q <= WAIT;
            lat_q   <= 3'(MEM_LAT);
          end
        end
        WAIT: begin
          lat_q <= lat_q - 3'd1;
          if (rd_done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  mem_lane_fmt u_fmt (
    .size_i     (size_q),
    .off_i      (off_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .rdata_i    (bus.mem_rdata),
    .be_o       (fmt_be),
    .wdata_o    (fmt_wdata),
    .rdata_o    (fmt_rdata)
  );

  assign bus.if_gnt    = if_win;
  assign bus.d_gnt     = d_win;
  assign bus.d_err     = d_win && d_bad;
  assign bus.if_rvalid = rd_done && (owner_q == REQ_IF);
  assign bus.d_rvalid  = rd_done && (owner_q == REQ_D);
  assign bus.if_rdata  = bus.if_rvalid ? fmt_rdata : 32'h0;
  assign bus.d_rdata   = bus.d_rvalid ? fmt_rdata : 32'h0;

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_en_q ? fmt_be : 4'b0000;
  assign bus.mem_wdata = mem_we_q ? fmt_wdata : 32'h0;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
// Bench memory array doubles as the reference model for stores and loads.
module tb_mem_arbiter;

  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] mem [0:255];
  int          rd_cnt = -1;
  logic [31:0] rd_word = 32'h0;

  // Advance to the next negedge and present this cycle's memory read data.
  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
    if (rd_cnt > 0) rd_cnt--;
    if (rd_cnt == 0) begin
      bus.mem_rdata = rd_word;
      rd_cnt = -1;
    end else begin
      bus.mem_rdata = $urandom;
    end
  endtask

  task automatic settle();
    #1;
    if (bus.mem_en === 1'b1 && bus.mem_we === 1'b0) begin
      rd_word = mem[bus.mem_addr[9:2]];
      rd_cnt  = MEM_LAT;
    end
  endtask

  task automatic drain();
    int n = 0;
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    while (bus.busy === 1'b1 && n < 20) begin
      next_cycle();
      settle();
      n++;
    end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL drain: busy=%b want 0 after %0d cycles", bus.busy, n);
    end
  endtask

  task automatic run_txn(input bit is_d, input bit we, input logic [31:0] addr,
                         input logic [1:0] size, input bit uns, input logic [31:0] wdata);
    logic [1:0]  sz;
    logic [1:0]  off;
    bit          wel;
    bit          misal;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [31:0] e_rd;
    logic [31:0] w;
    logic [31:0] b;
    logic [31:0] h;
    sz  = is_d ? size : 2'd2;
    off = is_d ? addr[1:0] : 2'd0;
    wel = is_d && we;
    w   = mem[addr[9:2]];
    b   = (w >> (8 * int'(off))) & 32'hFF;
    h   = (w >> (8 * int'(off))) & 32'hFFFF;
    misal = is_d && (sz == 2'd3 || (sz == 2'd1 && off[0]) || (sz == 2'd2 && off != 2'd0));
    case (sz)
      2'd0: begin
        e_be = 4'b0001 << off;
        e_wd = {24'h0, wdata[7:0]} * 32'h01010101;
        e_rd = (uns || b < 128) ? b : (b | 32'hFFFFFF00);
      end
      2'd1: begin
        e_be = 4'b0011 << off;
        e_wd = {16'h0, wdata[15:0]} * 32'h00010001;
        e_rd = (uns || h < 32768) ? h : (h | 32'hFFFF0000);
      end
      default: begin
        e_be = 4'b1111;
        e_wd = wdata;
        e_rd = w;
      end
    endcase

    if (is_d) begin
      bus.d_req = 1'b1; bus.d_we = wel; bus.d_addr = addr;
      bus.d_size = size; bus.d_unsigned = uns; bus.d_wdata = wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end
    settle();
    total++;
    if ({bus.if_gnt, bus.d_gnt, bus.d_err} !== {!is_d, is_d, misal}) begin
      bad++;
      $display("FAIL grant: got if_gnt/d_gnt/d_err=%b want %b addr=%h",
               {bus.if_gnt, bus.d_gnt, bus.d_err}, {!is_d, is_d, misal}, addr);
    end

    next_cycle();
    bus.d_req = 1'b0; bus.if_req = 1'b0;
    bus.d_we = 1'($urandom); bus.d_addr = $urandom; bus.d_size = 2'($urandom);
    bus.d_unsigned = 1'($urandom); bus.d_wdata = $urandom; bus.if_addr = $urandom;
    settle();
    if (misal) begin
      total++;
      if ({bus.mem_en, bus.busy, bus.d_rvalid} !== 3'b000) begin
        bad++;
        $display("FAIL err_noaccess: got en/busy/rvalid=%b want 000",
                 {bus.mem_en, bus.busy, bus.d_rvalid});
      end
      return;
    end

    total++;
    if ({bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.busy} !==
        {1'b1, wel, e_be, addr & 32'hFFFFFFFC, 1'b1}) begin
      bad++;
      $display("FAIL access: got en/we/be/addr/busy=%b/%b/%b/%h/%b want 1/%b/%b/%h/1",
               bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.busy,
               wel, e_be, addr & 32'hFFFFFFFC);
    end

    if (wel) begin
      total++;
      if (bus.mem_wdata !== e_wd) begin
        bad++;
        $display("FAIL wdata: got %h want %h", bus.mem_wdata, e_wd);
      end
      for (int i = 0; i < 4; i++)
        if (e_be[i]) mem[addr[9:2]][8*i +: 8] = e_wd[8*i +: 8];
      next_cycle();
      settle();
      total++;
      if ({bus.busy, bus.d_rvalid, bus.if_rvalid, bus.mem_en} !== 4'b0000) begin
        bad++;
        $display("FAIL store_done: got busy/d_rv/if_rv/en=%b want 0000",
                 {bus.busy, bus.d_rvalid, bus.if_rvalid, bus.mem_en});
      end
      return;
    end

    for (int i = 1; i <= MEM_LAT; i++) begin
      next_cycle();
      settle();
      total++;
      if ({bus.if_rvalid, bus.d_rvalid} !== {!is_d && i == MEM_LAT, is_d && i == MEM_LAT}) begin
        bad++;
        $display("FAIL rvalid: wait cycle %0d got if/d=%b%b", i, bus.if_rvalid, bus.d_rvalid);
      end
      if (i == MEM_LAT) begin
        total++;
        if ((is_d ? bus.d_rdata : bus.if_rdata) !== e_rd) begin
          bad++;
          $display("FAIL rdata: got %h want %h (size=%0d off=%0d uns=%0d)",
                   is_d ? bus.d_rdata : bus.if_rdata, e_rd, sz, off, uns);
        end
      end
    end
    next_cycle();
    settle();
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL rd_done: busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_reset();
    bus.if_req = 1'b0; bus.if_addr = 32'h0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.d_addr = 32'h0; bus.d_size = 2'd0; bus.d_unsigned = 1'b0; bus.d_wdata = 32'h0;
    bus.mem_rdata = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    rst_n = 1'b0;
    next_cycle();
    bus.if_req = 1'b1;
    settle();
    total++;
    if ({bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.d_gnt, bus.d_err, bus.d_rvalid,
         bus.d_rdata, bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata,
         bus.busy} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: some output nonzero in reset (if_gnt=%b busy=%b)",
               bus.if_gnt, bus.busy);
    end
    bus.if_req = 1'b0;
    rst_n = 1'b1;
    next_cycle();
    settle();
    total++;
    if ({bus.busy, bus.mem_en, bus.if_gnt, bus.d_gnt} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_idle: got busy/en/if_gnt/d_gnt=%b want 0000",
               {bus.busy, bus.mem_en, bus.if_gnt, bus.d_gnt});
    end
  endtask

  task automatic test_fetch();
    mem[8'h40] = 32'hDEADBEEF;
    run_txn(1'b0, 1'b0, 32'h100, 2'd2, 1'b0, 32'h0);
  endtask

  task automatic test_store_byte();
    run_txn(1'b1, 1'b1, 32'h203, 2'd0, 1'b0, 32'h000000A5);
  endtask

  task automatic test_load_half();
    mem[8'hC0] = 32'h80011234;
    run_txn(1'b1, 1'b0, 32'h302, 2'd1, 1'b0, 32'h0);
    run_txn(1'b1, 1'b0, 32'h302, 2'd1, 1'b1, 32'h0);
  endtask

  task automatic test_misaligned();
    run_txn(1'b1, 1'b0, 32'h401, 2'd2, 1'b0, 32'h0);
    run_txn(1'b1, 1'b1, 32'h203, 2'd1, 1'b0, 32'h1234);
    run_txn(1'b1, 1'b0, 32'h200, 2'd3, 1'b0, 32'h0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_txn(($urandom_range(0, 3) != 0), 1'($urandom), 32'($urandom_range(0, 1023)),
              2'($urandom), 1'($urandom), $urandom);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    for (int k = 0; k < 2; k++) begin
      bus.d_req = 1'b1; bus.d_we = (k == 1); bus.d_size = 2'd2;
      bus.d_addr = 32'h80; bus.d_unsigned = 1'b0; bus.d_wdata = $urandom;
      bus.if_req = 1'b1; bus.if_addr = 32'h84;
      if (k == 1) mem[8'h20] = bus.d_wdata;
      settle();
      total++;
      if ({bus.if_gnt, bus.d_gnt} !== 2'b01) begin
        bad++;
        $display("FAIL prio: got if_gnt/d_gnt=%b%b want 01", bus.if_gnt, bus.d_gnt);
      end
      n = 0;
      do begin
        next_cycle();
        if (n == 0) bus.d_req = 1'b0;
        settle();
        n++;
      end while (bus.if_gnt !== 1'b1 && n < 20);
      total++;
      if (n !== (k == 1 ? 2 : 2 + MEM_LAT)) begin
        bad++;
        $display("FAIL b2b_gap%0d: fetch granted after %0d cycles want %0d",
                 k, n, (k == 1 ? 2 : 2 + MEM_LAT));
      end
      next_cycle();
      bus.if_req = 1'b0;
      settle();
      drain();
    end
  endtask

  task automatic test_starve();
    int arb = 0;
    int if_arb = 0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 2'd2; bus.d_addr = 32'h10;
    bus.d_unsigned = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h20;
    settle();
    for (int n = 0; n < 200; n++) begin
      if (bus.d_gnt === 1'b1) arb++;
      if (bus.if_gnt === 1'b1) begin arb++; if_arb = arb; end
      if (if_arb != 0 || arb >= 10) break;
      next_cycle();
      settle();
    end
    next_cycle();
    bus.d_req = 1'b0; bus.if_req = 1'b0;
    settle();
    drain();
    total++;
`ifdef MEM_ARB_STARVE_GUARD_EN
    if (if_arb !== STARVE_MAX + 1) begin
      bad++;
      $display("FAIL starve_guard: fetch won arbitration %0d want %0d", if_arb, STARVE_MAX + 1);
    end
`else
    if ({arb, if_arb} !== {32'd10, 32'd0}) begin
      bad++;
      $display("FAIL strict_prio: arbitrations=%0d fetch_win_at=%0d want 10 and 0", arb, if_arb);
    end
`endif
  endtask

  task automatic test_reset_mid_wait();
    mem[8'h11] = 32'hCAFEF00D;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 2'd2; bus.d_addr = 32'h44; bus.d_unsigned = 1'b0;
    settle();
    next_cycle();
    bus.d_req = 1'b0;
    settle();
    next_cycle();
    settle();
    total++;
    if ({bus.busy, bus.mem_en, bus.d_rvalid} !== 3'b100) begin
      bad++;
      $display("FAIL wait_state: got busy/en/rvalid=%b want 100", {bus.busy, bus.mem_en, bus.d_rvalid});
    end
    bus.if_req = 1'b1; bus.if_addr = 32'h60;
    rst_n = 1'b0;
    settle();
    total++;
    if ({bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.d_gnt, bus.d_err, bus.d_rvalid,
         bus.d_rdata, bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata,
         bus.busy} !== '0) begin
      bad++;
      $display("FAIL reset_mid: outputs nonzero (busy=%b d_rvalid=%b if_gnt=%b)",
               bus.busy, bus.d_rvalid, bus.if_gnt);
    end
    next_cycle();
    bus.if_req = 1'b0;
    rst_n = 1'b1;
    settle();
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      settle();
      total++;
      if ({bus.if_rvalid, bus.d_rvalid, bus.busy} !== 3'b000) begin
        bad++;
        $display("FAIL post_reset: cycle %0d got if_rv/d_rv/busy=%b want 000",
                 i, {bus.if_rvalid, bus.d_rvalid, bus.busy});
      end
    end
    run_txn(1'b0, 1'b0, 32'h44, 2'd2, 1'b0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_byte();
    test_load_half();
    test_misaligned();
    test_random();
    test_back_to_back();
    test_starve();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
